// File: rtl/sdram_sched_pkg.sv
// Shared encodings for the SDRAM burst scheduler: command opcodes, FSM states
// and default burst/FIFO sizing.
package sdram_sched_pkg;

    localparam int BURST_DEF      = 128;
    localparam int FIFO_DEPTH_DEF = 512;

    typedef enum logic [1:0] {
        OP_REFRESH = 2'd0,
        OP_WRITE   = 2'd1,
        OP_READ1   = 2'd2,
        OP_READ2   = 2'd3
    } cmd_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_t;

endpackage

// File: rtl/port_addr_gen.sv
// Wrapping burst address pointer for one frame-buffer port. A load restarts
// the pointer at BASE and overrides a simultaneous advance.
module port_addr_gen
    import sdram_sched_pkg::*;
#(
    parameter int ADDR_W = 23,
    parameter int BASE   = 0,
    parameter int MAX    = 324480,
    parameter int BURST  = BURST_DEF
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              load,
    input  logic              advance,
    output logic [ADDR_W-1:0] ptr
);

    localparam logic [ADDR_W:0]   BURST_EXT = (ADDR_W+1)'(BURST);
    localparam logic [ADDR_W:0]   MAX_EXT   = (ADDR_W+1)'(MAX);
    localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);

    // One extra bit so the wrap compare never sees an overflowed sum.
    logic [ADDR_W:0] next_ptr;
    assign next_ptr = {1'b0, ptr} + BURST_EXT;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            ptr <= BASE_ADDR;
        end else if (load) begin
            ptr <= BASE_ADDR;
        end else if (advance) begin
            ptr <= (next_ptr >= MAX_EXT) ? BASE_ADDR : next_ptr[ADDR_W-1:0];
        end
    end

endmodule

// File: rtl/sdram_burst_scheduler.sv
// Picks one SDRAM burst at a time (refresh, video write, odd/even field read)
// from FIFO levels and presents it to the command engine over valid/ready.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | evaluate requests, latch the winning command
//   ST_ISSUE | cmd_valid held with stable fields until cmd_ready
//   ST_BUSY  | command accepted, waiting for burst_done
module sdram_burst_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int ADDR_W     = 23,
    parameter int LEN_W      = 9,
    parameter int BURST      = BURST_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int WR_BASE    = 0,
    parameter int WR_MAX     = 324480,
    parameter int RD1_BASE   = 8320,
    parameter int RD1_MAX    = 161920,
    parameter int RD2_BASE   = 170880,
    parameter int RD2_MAX    = 324480
) (
    input  logic              clk,
    input  logic              areset,
    input  logic [LEN_W:0]    wr_level,
    input  logic [LEN_W:0]    rd1_level,
    input  logic [LEN_W:0]    rd2_level,
    input  logic              wr_load,
    input  logic              rd1_load,
    input  logic              rd2_load,
    input  logic              ref_req,
    output logic              cmd_valid,
    output logic [1:0]        cmd_op,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [LEN_W-1:0]  cmd_len,
    input  logic              cmd_ready,
    input  logic              burst_done,
    output logic              busy
);

    localparam logic [LEN_W:0]   LVL_WRITE = (LEN_W+1)'(BURST);
    localparam logic [LEN_W:0]   LVL_READ  = (LEN_W+1)'(FIFO_DEPTH - BURST);
    localparam logic [LEN_W-1:0] LEN_BURST = LEN_W'(BURST);

    state_t            state;
    logic              last_rd2;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd1_ptr;
    logic [ADDR_W-1:0] rd2_ptr;

    logic wreq;
    logic r1req;
    logic r2req;
    assign wreq  = (wr_level  >= LVL_WRITE) && !wr_load;
    assign r1req = (rd1_level <= LVL_READ)  && !rd1_load;
    assign r2req = (rd2_level <= LVL_READ)  && !rd2_load;

    logic              sel_valid;
    cmd_op_t           sel_op;
    logic [ADDR_W-1:0] sel_addr;
    logic [LEN_W-1:0]  sel_len;

    always_comb begin
        sel_valid = 1'b0;
        sel_op    = OP_REFRESH;
        sel_addr  = '0;
        sel_len   = '0;
        if (ref_req) begin
            sel_valid = 1'b1;
        end else if (wreq) begin
            sel_valid = 1'b1;
            sel_op    = OP_WRITE;
            sel_addr  = wr_ptr;
            sel_len   = LEN_BURST;
        end else if (r1req && (!r2req || last_rd2)) begin
            sel_valid = 1'b1;
            sel_op    = OP_READ1;
            sel_addr  = rd1_ptr;
            sel_len   = LEN_BURST;
        end else if (r2req) begin
            sel_valid = 1'b1;
            sel_op    = OP_READ2;
            sel_addr  = rd2_ptr;
            sel_len   = LEN_BURST;
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state     <= ST_IDLE;
            cmd_valid <= 1'b0;
            cmd_op    <= '0;
            cmd_addr  <= '0;
            cmd_len   <= '0;
            busy      <= 1'b0;
            last_rd2  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sel_valid) begin
                        cmd_valid <= 1'b1;
                        busy      <= 1'b1;
                        cmd_op    <= sel_op;
                        cmd_addr  <= sel_addr;
                        cmd_len   <= sel_len;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state     <= ST_BUSY;
                        if (cmd_op == OP_READ1) begin
                            last_rd2 <= 1'b0;
                        end else if (cmd_op == OP_READ2) begin
                            last_rd2 <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (burst_done) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Pointers move only when the outstanding burst actually completes.
    logic done_ok;
    assign done_ok = (state == ST_BUSY) && burst_done;

    port_addr_gen #(
        .ADDR_W (ADDR_W),
        .BASE   (WR_BASE),
        .MAX    (WR_MAX),
        .BURST  (BURST)
    ) u_wr_ptr (
        .clk     (clk),
        .areset  (areset),
        .load    (wr_load),
        .advance (done_ok && (cmd_op == OP_WRITE)),
        .ptr     (wr_ptr)
    );

    port_addr_gen #(
        .ADDR_W (ADDR_W),
        .BASE   (RD1_BASE),
        .MAX    (RD1_MAX),
        .BURST  (BURST)
    ) u_rd1_ptr (
        .clk     (clk),
        .areset  (areset),
        .load    (rd1_load),
        .advance (done_ok && (cmd_op == OP_READ1)),
        .ptr     (rd1_ptr)
    );

    port_addr_gen #(
        .ADDR_W (ADDR_W),
        .BASE   (RD2_BASE),
        .MAX    (RD2_MAX),
        .BURST  (BURST)
    ) u_rd2_ptr (
        .clk     (clk),
        .areset  (areset),
        .load    (rd2_load),
        .advance (done_ok && (cmd_op == OP_READ2)),
        .ptr     (rd2_ptr)
    );

endmodule

// File: doc/sdram_burst_scheduler.md
Name: sdram_burst_scheduler

Overview:
- Schedules bursts on the shared 4-port SDRAM frame buffer: one video-input write stream (WR1), odd-field read (RD1), even-field read (RD2), plus auto-refresh.
- Watches FIFO fill levels, picks one burst at a time, and issues op/address/length to the SDRAM command engine over a valid/ready handshake.
- Keeps a wrapping address pointer per port.
- Sits between the port FIFOs and the SDRAM command/timing engine, all in the TD_CLK27 domain.

Parameters:
ADDR_W, 23, SDRAM word address width
LEN_W, 9, burst length width
BURST, 128, words per burst (constant cmd_len)
FIFO_DEPTH, 512, depth of every port FIFO
WR_BASE, 0, write start address
WR_MAX, 324480, write wrap address (640*507)
RD1_BASE, 8320, odd-field start (640*13)
RD1_MAX, 161920, odd-field wrap (640*253)
RD2_BASE, 170880, even-field start (640*267)
RD2_MAX, 324480, even-field wrap (640*507)

Ports:
clk  in  1  TD_CLK27 domain clock
areset  in  1  async active-high reset
wr_level  in  LEN_W+1  WR1 FIFO used words
rd1_level  in  LEN_W+1  RD1 FIFO used words
rd2_level  in  LEN_W+1  RD2 FIFO used words
wr_load  in  1  pulse: restart WR pointer at WR_BASE
rd1_load  in  1  pulse: restart RD1 pointer at RD1_BASE
rd2_load  in  1  pulse: restart RD2 pointer at RD2_BASE
ref_req  in  1  refresh due (level, held until serviced)
cmd_valid  out  1  command presented
cmd_op  out  2  0=REFRESH 1=WRITE 2=READ1 3=READ2
cmd_addr  out  ADDR_W  burst start address (0 for REFRESH)
cmd_len  out  LEN_W  BURST (0 for REFRESH)
cmd_ready  in  1  engine accepts command
burst_done  in  1  pulse: accepted command complete
busy  out  1  command outstanding (ISSUE or BUSY)

Behaviour:
- Reset (async, while areset=1):
  - outputs: cmd_valid=0, cmd_op=0, cmd_addr=0, cmd_len=0, busy=0
  - pointers: WR_BASE, RD1_BASE, RD2_BASE
  - round-robin last-read = RD2, so RD1 wins first.
- Request terms, evaluated in IDLE only:
  - wreq = wr_level >= BURST
  - r1req = rd1_level <= FIFO_DEPTH-BURST
  - r2req = rd2_level <= FIFO_DEPTH-BURST
  - A port's request is masked in any cycle its load pulse is high.
- Priority: ref_req > wreq > reads. Reads alternate round-robin when both request; a single requester always wins.
- FSM IDLE -> ISSUE -> BUSY -> IDLE:
  - IDLE: if any request, register op/addr/len, assert cmd_valid next cycle, go to ISSUE. No request: stay.
  - ISSUE: hold cmd_valid, cmd_op, cmd_addr and cmd_len stable until cmd_ready=1. Acceptance cycle: cmd_valid drops next cycle, go to BUSY. Update the round-robin pointer on read acceptance.
  - BUSY: wait for burst_done, then go to IDLE. burst_done in IDLE or ISSUE is ignored.
  - Minimum spacing: one IDLE cycle between bursts.
  - Latency: request visible in IDLE -> cmd_valid=1 one cycle later.
- busy=1 in ISSUE and BUSY.
- Pointer advance on burst_done of a WRITE/READ1/READ2:
  - next = ptr + BURST
  - if next >= MAX, next = BASE (wrap; no partial burst)
  - REFRESH moves no pointer.
- Load pulse:
  - sets that pointer to BASE in the next cycle, in any state.
  - If it coincides with burst_done for the same port, load wins: pointer = BASE, no advance.
  - A load during that port's ISSUE does not alter the presented cmd_addr.
- Widths: pointer arithmetic in ADDR_W+1 bits for the compare, so there is no overflow.

Decomposition:
- Shared package sdram_sched_pkg:
  - cmd_op encodings OP_REFRESH/OP_WRITE/OP_READ1/OP_READ2
  - FSM state enum ST_IDLE/ST_ISSUE/ST_BUSY
  - default BURST/FIFO_DEPTH constants
- Sub-module port_addr_gen (params BASE, MAX, BURST), instanced 3x.
  - Inputs: clk, areset, load, advance.
  - Output: ptr.
  - Load priority over advance.

Test Plan:
- Reset, then wr_level=128, others 512 -> cmd_valid=1 two cycles after reset release; op=1, addr=0, len=128. After ready and done, the next write has addr=128.
- ref_req=1 and wr_level=200 together in IDLE -> REFRESH issued first (addr=0, len=0), then WRITE after done.
- rd1_level=rd2_level=0, wr_level=0 -> READ1 at 8320, READ2 at 170880, READ1 at 8448, alternating.
- cmd_ready held low 10 cycles in ISSUE -> cmd_valid and fields stable all 10 cycles; burst_done pulses during ISSUE are ignored.
- Set the RD1 pointer to 161792 (via repeated bursts), complete one READ1 -> pointer wraps to 8320, not 161920.
- wr_load coincident with burst_done of a WRITE at addr 256 -> next WRITE addr=0; areset mid-BUSY -> all outputs 0 immediately, pointers at bases.
